// File: rtl/icap_fifo_interface.sv
// icap_fifo_interface: buffered ICAP write port.
// Register writes queue configuration words in a FIFO. A drain FSM issues
// the queued words to ICAP one per clock while icap_busy is low. A pending
// read command is issued only after every queued word has gone out.
module icap_fifo_interface #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BIT_SWAP   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wready,
  input  logic [7:0]                    address,
  input  logic [BUS_WIDTH-1:0]          wrdata,
  input  logic                          icap_busy,
  output logic                          write_req,
  output logic                          read_req,
  output logic [BUS_WIDTH-1:0]          icap_wrdata,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  // Reverse the bit order inside every byte when the ICAP expects Xilinx ordering.
  function automatic logic [BUS_WIDTH-1:0] swap_bits(input logic [BUS_WIDTH-1:0] w);
    logic [BUS_WIDTH-1:0] r;
    r = w;
    if (BIT_SWAP != 0) begin
      for (int k = 0; k < BUS_WIDTH/8; k++) begin
        for (int b = 0; b < 8; b++) begin
          r[8*k+b] = w[8*k+7-b];
        end
      end
    end
    return r;
  endfunction

  logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          level_q;
  logic                 read_pending_q;
  logic                 overflow_q;
  state_t               state_q;
  logic                 write_req_q, read_req_q;
  logic [BUS_WIDTH-1:0] wrdata_q;

  logic push_cmd_s, rdreq_s, ctrl_s, flush_s, clr_ovf_s;
  logic empty_s, full_s, push_s, drop_s, pop_s, rd_issue_s;

  // Decode the register write and the drain decision for this cycle.
  always_comb begin
    push_cmd_s = wready && (address == 8'h00);
    rdreq_s    = wready && (address == 8'h01) && (wrdata != '0);
    ctrl_s     = wready && (address == 8'h02);
    flush_s    = ctrl_s && wrdata[1];
    clr_ovf_s  = ctrl_s && wrdata[0];
    empty_s    = (level_q == '0);
    full_s     = (level_q == DEPTH_LVL);
    // Fullness is judged on the level before any same-cycle pop.
    push_s     = push_cmd_s && !full_s && !flush_s;
    drop_s     = push_cmd_s && full_s && !flush_s;
    pop_s      = !icap_busy && !empty_s;
    rd_issue_s = !icap_busy && empty_s && read_pending_q;
  end

  // FIFO storage; contents need no reset because the level tracks validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= wrdata;
    end
  end

  // FIFO pointers and occupancy; a flush empties the FIFO even if a pop issues this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_s) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_s) wptr_q <= wptr_q + AW'(1);
      if (pop_s)  rptr_q <= rptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Read-request flag (repeat requests merge) and sticky overflow (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (flush_s || rd_issue_s) read_pending_q <= 1'b0;
      else if (rdreq_s)          read_pending_q <= 1'b1;
      else                       read_pending_q <= read_pending_q;
      if (drop_s)         overflow_q <= 1'b1;
      else if (clr_ovf_s) overflow_q <= 1'b0;
      else                overflow_q <= overflow_q;
    end
  end

  // Drain FSM: every state takes the same issue decision, so words stream at one per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      wrdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE, WRITE, READ: begin
          if (pop_s) begin
            state_q     <= WRITE;
            write_req_q <= 1'b1;
            read_req_q  <= 1'b0;
            wrdata_q    <= swap_bits(mem_q[rptr_q]);
          end else if (rd_issue_s) begin
            state_q     <= READ;
            write_req_q <= 1'b0;
            read_req_q  <= 1'b1;
            wrdata_q    <= {BUS_WIDTH{1'b1}};
          end else begin
            state_q     <= IDLE;
            write_req_q <= 1'b0;
            read_req_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          write_req_q <= 1'b0;
          read_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_req   = write_req_q;
  assign read_req    = read_req_q;
  assign icap_wrdata = wrdata_q;
  assign fifo_full   = full_s;
  assign fifo_empty  = empty_s;
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_icap_fifo_interface.sv
// Directed bench for icap_fifo_interface: one plain instance and one with
// per-byte bit reversal, both driven by the same stimulus.
module tb_icap_fifo_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wready = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] wrdata = 32'h0;
  logic        icap_busy = 1'b0;

  logic        write_req, read_req, fifo_full, fifo_empty, overflow;
  logic [31:0] icap_wrdata;
  logic [4:0]  fifo_level;
  logic        s_write_req, s_read_req, s_fifo_full, s_fifo_empty, s_overflow;
  logic [31:0] s_icap_wrdata;
  logic [4:0]  s_fifo_level;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icap_fifo_interface #(.BUS_WIDTH(32), .FIFO_DEPTH(16), .BIT_SWAP(0)) u_dut (
    .clk(clk), .rst(rst), .wready(wready), .address(address), .wrdata(wrdata),
    .icap_busy(icap_busy), .write_req(write_req), .read_req(read_req),
    .icap_wrdata(icap_wrdata), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .overflow(overflow));

  icap_fifo_interface #(.BUS_WIDTH(32), .FIFO_DEPTH(16), .BIT_SWAP(1)) u_swp (
    .clk(clk), .rst(rst), .wready(wready), .address(address), .wrdata(wrdata),
    .icap_busy(icap_busy), .write_req(s_write_req), .read_req(s_read_req),
    .icap_wrdata(s_icap_wrdata), .fifo_full(s_fifo_full), .fifo_empty(s_fifo_empty),
    .fifo_level(s_fifo_level), .overflow(s_overflow));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wready  = 1'b1;
    address = a;
    wrdata  = d;
    tick();
    wready  = 1'b0;
  endtask

  logic [31:0] w4 [4];

  initial begin
    w4[0] = 32'h11111111; w4[1] = 32'h22222222; w4[2] = 32'h33333333; w4[3] = 32'h44444444;

    // Reset state
    tick();
    chk("rst_write_req", {31'd0, write_req}, 32'd0);
    chk("rst_read_req", {31'd0, read_req}, 32'd0);
    chk("rst_wrdata", icap_wrdata, 32'h0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Single push: pulse appears two cycles after the strobe
    wr(8'h00, 32'hAA995566);
    chk("t1_no_pulse_yet", {31'd0, write_req}, 32'd0);
    chk("t1_level1", {27'd0, fifo_level}, 32'd1);
    tick();
    chk("t1_write_req", {31'd0, write_req}, 32'd1);
    chk("t1_data", icap_wrdata, 32'hAA995566);
    tick();
    chk("t1_pulse_end", {31'd0, write_req}, 32'd0);
    chk("t1_hold", icap_wrdata, 32'hAA995566);
    chk("t1_empty", {31'd0, fifo_empty}, 32'd1);

    // Four back-to-back pushes stream out in order
    for (int k = 0; k < 4; k++) begin
      wr(8'h00, w4[k]);
      chk("t2_level", {27'd0, fifo_level}, 32'd1);
      if (k > 0) begin
        chk("t2_write_req", {31'd0, write_req}, 32'd1);
        chk("t2_data", icap_wrdata, w4[k-1]);
      end
    end
    tick();
    chk("t2_last_req", {31'd0, write_req}, 32'd1);
    chk("t2_last_data", icap_wrdata, w4[3]);
    chk("t2_level0", {27'd0, fifo_level}, 32'd0);
    tick();
    chk("t2_idle", {31'd0, write_req}, 32'd0);

    // Fill past full while busy, then drain exactly 16 words (pointers wrap)
    icap_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h00, 32'h100 + i);
    chk("t3_full", {31'd0, fifo_full}, 32'd1);
    chk("t3_level16", {27'd0, fifo_level}, 32'd16);
    chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    chk("t3_busy_no_pulse", {31'd0, write_req}, 32'd0);
    wr(8'h00, 32'hDEADBEEF);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_level_still16", {27'd0, fifo_level}, 32'd16);
    icap_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t3_drain_req", {31'd0, write_req}, 32'd1);
      chk("t3_drain_data", icap_wrdata, 32'h100 + i);
    end
    chk("t3_drained", {27'd0, fifo_level}, 32'd0);
    tick();
    chk("t3_no_extra", {31'd0, write_req}, 32'd0);
    wr(8'h02, 32'h1);
    chk("t3_ovf_clear", {31'd0, overflow}, 32'd0);
    wr(8'h05, 32'h12345678);
    chk("t3_bad_addr", {27'd0, fifo_level}, 32'd0);

    // Read request queued behind two writes
    wr(8'h00, 32'hA0A0A0A0);
    wr(8'h00, 32'hB0B0B0B0);
    chk("t4_w0_req", {31'd0, write_req}, 32'd1);
    chk("t4_w0_data", icap_wrdata, 32'hA0A0A0A0);
    wr(8'h01, 32'h1);
    chk("t4_w1_req", {31'd0, write_req}, 32'd1);
    chk("t4_w1_data", icap_wrdata, 32'hB0B0B0B0);
    chk("t4_no_read_yet", {31'd0, read_req}, 32'd0);
    tick();
    chk("t4_read_req", {31'd0, read_req}, 32'd1);
    chk("t4_write_low", {31'd0, write_req}, 32'd0);
    chk("t4_read_word", icap_wrdata, 32'hFFFFFFFF);
    chk("t4_swp_read_word", s_icap_wrdata, 32'hFFFFFFFF);
    tick();
    chk("t4_read_end", {31'd0, read_req}, 32'd0);
    chk("t4_read_hold", icap_wrdata, 32'hFFFFFFFF);

    // Per-byte bit reversal applies to write words only
    wr(8'h00, 32'h01020304);
    tick();
    chk("t5_plain", icap_wrdata, 32'h01020304);
    chk("t5_swapped", s_icap_wrdata, 32'h8040C020);
    chk("t5_swp_req", {31'd0, s_write_req}, 32'd1);
    tick();
    chk("t5_swp_hold", s_icap_wrdata, 32'h8040C020);

    // Flush drops queued words and the pending read
    icap_busy = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'h00, 32'h200 + i);
    chk("t6_level8", {27'd0, fifo_level}, 32'd8);
    wr(8'h01, 32'h1);
    wr(8'h02, 32'h2);
    chk("t6_flush_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t6_flush_level", {27'd0, fifo_level}, 32'd0);
    icap_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_write", {31'd0, write_req}, 32'd0);
      chk("t6_no_read", {31'd0, read_req}, 32'd0);
    end

    // Reset asserted during a burst kills the pulse at once and the queue
    wr(8'h00, 32'h300);
    wr(8'h00, 32'h301);
    wready  = 1'b1;
    address = 8'h00;
    wrdata  = 32'h302;
    chk("t7_burst_req", {31'd0, write_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_async_drop", {31'd0, write_req}, 32'd0);
    chk("t7_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t7_level", {27'd0, fifo_level}, 32'd0);
    wready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_quiet_write", {31'd0, write_req}, 32'd0);
      chk("t7_quiet_read", {31'd0, read_req}, 32'd0);
    end
    chk("t7_final_level", {27'd0, fifo_level}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
